// File: rtl/tristate_bus_arbiter_if.sv
// Request/grant bundle between the requesting units and the tristate bus arbiter.
// The shared tristate line itself stays a plain net on the arbiter.
interface tristate_bus_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] din;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        oe;
  logic [IDX_W-1:0]        owner;
  logic                    busy;

  modport master (
    input  req,
    input  din,
    output gnt,
    output oe,
    output owner,
    output busy
  );

  modport slave (
    output req,
    output din,
    input  gnt,
    input  oe,
    input  owner,
    input  busy
  );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner sequencer for a shared tristate line: bounded ownership,
// a high-Z turnaround gap between owners, and one bufif1 bank per requester.
module tristate_bus_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = 8,
  parameter int MAX_HOLD   = 4,
  parameter int TURNAROUND = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tristate_bus_arbiter_if.master bus_if,
  inout  tri   [DATA_W-1:0]     bus
);
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int TURN_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_TURN  = 2'd2;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURNAROUND - 1);
  localparam logic [IDX_W-1:0]  PTR_RST   = IDX_W'(N_REQ - 1);

  logic [1:0]              state_q, state_d;
  logic [N_REQ-1:0]        gnt_q, gnt_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic [TURN_W-1:0]       turn_q, turn_d;

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] din;
  logic                    win_vld;
  logic [IDX_W-1:0]        win_idx;
  logic [N_REQ-1:0]        win_oh;

  assign req = bus_if.req;
  assign din = bus_if.din;

  // Walk from the lowest priority slot upward so the last hit is the one nearest ptr+1.
  always_comb begin
    int k;
    win_vld = 1'b0;
    win_idx = '0;
    k       = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      k = (int'(ptr_q) + i) % N_REQ;
      if (req[k[IDX_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = k[IDX_W-1:0];
      end
    end
  end

  assign win_oh = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_GRANT;
          gnt_d   = win_oh;
          owner_d = win_idx;
          ptr_d   = win_idx;
          hold_d  = '0;
        end
      end
      S_GRANT: begin
        if (!req[owner_q] || (hold_q == HOLD_LAST)) begin
          state_d = S_TURN;
          gnt_d   = '0;
          turn_d  = '0;
        end else begin
          hold_d  = hold_q + HOLD_W'(1);
        end
      end
      S_TURN: begin
        if (turn_q == TURN_LAST) begin
          if (win_vld) begin
            state_d = S_GRANT;
            gnt_d   = win_oh;
            owner_d = win_idx;
            ptr_d   = win_idx;
            hold_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          turn_d = turn_q + TURN_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Asynchronous reset drops the enables at once, so the line floats mid-cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= PTR_RST;
      hold_q  <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
    end
  end

  assign bus_if.gnt   = gnt_q;
  assign bus_if.oe    = gnt_q;
  assign bus_if.owner = owner_q;
  assign bus_if.busy  = (state_q == S_GRANT);

  for (genvar k = 0; k < N_REQ; k++) begin : g_req
    for (genvar b = 0; b < DATA_W; b++) begin : g_bit
      bufif1 u_drv (bus[b], din[k*DATA_W + b], gnt_q[k]);
    end
  end
endmodule

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared tristate data line.
- N_REQ requesters each offer a data word. The block grants exactly one requester at a time and drives that requester's word onto the shared bus through per-requester bufif1 drivers.
- It enforces a maximum ownership time and a turnaround gap with the bus at high-Z between owners, so two drivers never contend.
- It sits between the requesting units and the shared bus, replacing ad-hoc select logic on bufif0/bufif1 muxes.

Parameters:
- N_REQ, 4, number of requesters, legal range 2..8.
- DATA_W, 8, bus and per-requester data width.
- MAX_HOLD, 4, maximum consecutive GRANT cycles per ownership, minimum 1.
- TURNAROUND, 1, high-Z cycles between owners, legal range 1..4.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  N_REQ  request per requester, level-sensitive.
- din  input  N_REQ*DATA_W  requester data; requester k occupies bits [k*DATA_W +: DATA_W].
- gnt  output  N_REQ  registered one-hot grant.
- oe  output  N_REQ  registered drive enables to the bufif1 drivers; equal to gnt.
- owner  output  clog2(N_REQ)  index of the current or last grantee.
- busy  output  1  high while in GRANT.
- bus  output (tri)  DATA_W  shared line; carries din[owner] when any oe bit is set, otherwise z.

Behaviour:
- Reset: rst_n low forces the following immediately, without waiting for a clock edge:
  - state=IDLE
  - gnt=0, oe=0, busy=0, owner=0
  - bus=all z
  - hold counter=0, turnaround counter=0
  - round-robin pointer=N_REQ-1, so requester 0 has first priority.
- Reset asserted mid-grant releases the bus immediately.
- Arbitration:
  - Combinational search starting at pointer+1 modulo N_REQ for the first set req bit.
  - On grant, the pointer is updated to the winner index.
- FSM states:
  - IDLE: gnt=0. If any req is set, latch the winner, go to GRANT. Grant appears one cycle after req is sampled.
  - GRANT: gnt[k]=oe[k]=1, busy=1, owner=k. Hold counter increments each cycle. Leave to TURN when req[k] is sampled low, or when the hold counter reaches MAX_HOLD-1 (ownership lasts at most MAX_HOLD cycles). The transition clears gnt/oe on that edge.
  - TURN: gnt=oe=0, bus z, for exactly TURNAROUND cycles. On the last TURN cycle, if any req is set, go to GRANT with the new winner; otherwise go to IDLE.
- Preempted owner: a requester that still holds req after preemption can be re-granted only after TURN, and only when round-robin order reaches it again. A lone requester is re-granted after TURN.
- req changes during TURN are honoured. Only the value sampled on the last TURN cycle decides the next winner.
- Invariants:
  - popcount(oe)<=1 at all times.
  - oe is all zero for at least TURNAROUND cycles between any two GRANT periods, including same-owner regrants.
- Bus driving: bus is driven only by the bufif1 of the enabled requester; no other driver exists inside the block.
- Counter width: clog2(MAX_HOLD+1). The turnaround counter width is sized for TURNAROUND.
- din is not registered; bus follows din[owner] combinationally while oe is set.

Test Plan:
(All scenarios use N_REQ=4, DATA_W=8, MAX_HOLD=4, TURNAROUND=1.)
- Reset: rst_n=0 with req=1111.
  -> gnt=0000, oe=0000, busy=0, bus=zzzzzzzz.
  -> After release, first grant is 0001.
- Single request: req=0100, din2=8'hA5.
  -> Next edge: gnt=0100, bus=A5.
  -> Drop req: next edge oe=0000 and bus=z for 1 cycle, then IDLE.
- Full contention: req=1111 held continuously.
  -> Grant order 0,1,2,3,0.
  -> Each ownership is 4 cycles, separated by 1 z cycle.
  -> popcount(oe) never exceeds 1.
- Hold limit: req=0001 held alone.
  -> Pattern repeats: 4 cycles gnt=0001, 1 cycle gnt=0000, regrant 0001.
- Asynchronous reset mid-grant: assert rst_n low between clock edges while gnt=0010.
  -> oe=0000 and bus=z before the next edge.
  -> Release with req=1001: grant 0001 first.
- Request during TURN: owner 1 drops req, and req=1000 rises in the TURN cycle.
  -> GRANT 1000 on the edge after TURN, no IDLE cycle.
  -> If req=0000 instead, go to IDLE.
